// File: rtl/hrm_pkg.sv
// hrm_pkg: shared word width and mailbox depth for the outbox/inbox blocks
package hrm_pkg;
    localparam int HRM_DATA_W = 8;
    localparam int HRM_BOX_DEPTH = 16;
endpackage

// File: rtl/outbox_fifo_if.sv
// outbox_fifo_if: control-unit write side and consumer valid/ready side of the outbox
interface outbox_fifo_if
    import hrm_pkg::*;
#(
    parameter int DATA_W = HRM_DATA_W,
    parameter int DEPTH = HRM_BOX_DEPTH
) ();
    localparam int AW = $clog2(DEPTH);
    logic wO;
    logic [DATA_W-1:0] din;
    logic outFull;
    logic o_valid;
    logic [DATA_W-1:0] o_data;
    logic o_ready;
    logic [AW:0] count;
    logic ovf;
    modport master (output wO, din, o_ready, input outFull, o_valid, o_data, count, ovf);
    modport slave (input wO, din, o_ready, output outFull, o_valid, o_data, count, ovf);
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W storage with synchronous write and asynchronous read
module fifo_mem
    import hrm_pkg::*;
#(
    parameter int DATA_W = HRM_DATA_W,
    parameter int DEPTH = HRM_BOX_DEPTH,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    // store the incoming word; contents survive reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/outbox_fifo.sv
// outbox_fifo: FIFO between the CPU outbox strobe and a valid/ready consumer
module outbox_fifo
    import hrm_pkg::*;
#(
    parameter int DATA_W = HRM_DATA_W,
    parameter int DEPTH = HRM_BOX_DEPTH
) (
    input  logic clk,
    input  logic i_rst,
    input  logic clr,
    outbox_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic ovf_q, flush, do_wr, do_rd;
    assign flush = i_rst | clr;
    assign bus.outFull = cnt == FULL_CNT;
    assign bus.o_valid = cnt != '0;
    assign bus.count = cnt;
    assign bus.ovf = ovf_q;
    // full is judged on the current count, so a write at full is dropped even if a read frees a slot
    assign do_wr = bus.wO & ~bus.outFull;
    assign do_rd = bus.o_valid & bus.o_ready;
    fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (do_wr & ~flush),
        .waddr (wp),
        .wdata (bus.din),
        .raddr (rp),
        .rdata (bus.o_data)
    );
    // pointers, occupancy and sticky overflow; flush wins over any concurrent transfer
    always_ff @(posedge clk) begin
        if (flush) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_wr) wp <= wp + 1'b1;
            if (do_rd) rp <= rp + 1'b1;
            cnt <= (do_wr && !do_rd) ? cnt + 1'b1 : (do_rd && !do_wr) ? cnt - 1'b1 : cnt;
            if (bus.wO && bus.outFull) ovf_q <= 1'b1;
        end
    end
endmodule

// File: doc/outbox_fifo.md
# outbox_fifo

CPU-side responder for the outbox handshake. Accepts one data word per `wO` strobe from the control path and returns `outFull` for the control unit's DECODE-stage stall test. Buffers words in first-in/first-out order and presents them to a downstream consumer (display, UART TX, test harness) over a valid/ready port. Sits between the datapath register R / control unit and the board-level output logic.

## Interface
- `DATA_W`, 8: word width; matches register R.
- `DEPTH`, 16: number of entries; must be a power of two, at least 2.
- `AW`, $clog2(DEPTH): derived pointer width; not to be overridden.

Ports:
- `clk` input, 1: the single clock; all state changes on its rising edge.
- `i_rst` input, 1: synchronous, active-high reset.
- `clr` input, 1: synchronous flush, driven by the control unit's `rst` output. Same effect as `i_rst`.
- `wO` input, 1: write strobe from the control unit (OUTBOX state).
- `din` input, DATA_W: word to enqueue, sampled when `wO`=1.
- `outFull` output, 1: count == DEPTH.
- `o_valid` output, 1: count != 0.
- `o_data` output, DATA_W: head-of-queue word. Valid only while `o_valid`=1.
- `o_ready` input, 1: consumer accepts the head word when `o_valid`=1.
- `count` output, AW+1: current occupancy, 0..DEPTH.
- `ovf` output, 1: sticky flag, set by a write attempted while full.

## Operation
- Storage is a DEPTH-entry array with write pointer `wp`, read pointer `rp` (AW bits each, wrap modulo DEPTH) and occupancy counter `cnt` (AW+1 bits).
- Write condition `do_wr` = `wO` & ~`outFull`. When true, `mem[wp]` <= `din` and `wp` increments.
- Read condition `do_rd` = `o_valid` & `o_ready`. When true, `rp` increments.
- Counter update:
  - `do_wr` only: `cnt`+1.
  - `do_rd` only: `cnt`-1.
  - Both or neither: `cnt` unchanged.
- Simultaneous read and write at 0 < `cnt` < DEPTH: both are performed and order is preserved.
- Simultaneous read and write at `cnt`=DEPTH: the write is rejected, because `outFull` is evaluated on the current count. There is no same-cycle pass-through. The read proceeds and `ovf` is set.
- Write at `cnt`=0: no bypass. `o_valid` rises the next cycle.
- `wO` while full: data is dropped and no pointer moves. `ovf` <= 1 and stays set until `i_rst` or `clr`.
- `o_ready` with `o_valid`=0: ignored, no pointer moves.
- `i_rst` or `clr`: `wp`=`rp`=0, `cnt`=0, `ovf`=0. This takes priority over a concurrent read or write in the same cycle. Array contents are not cleared.
- Reset values of outputs:
  - `outFull`=0, `o_valid`=0, `count`=0, `ovf`=0.
  - `o_data` is don't-care; it is `mem[0]` contents.
- No internal FSM beyond the pointer/counter state. Occupancy is the sole state variable observed externally.

## Timing
- `outFull`, `o_valid` and `count` are registered-state decodes (pure functions of `cnt`). They are glitch-free and change only after a clock edge.
- `o_data` = `mem[rp]` is an asynchronous read (distributed RAM). It is updated in the cycle after `rp` or the head entry changes.
- Write-to-output latency on an empty queue: 1 cycle.
- Read throughput: one word per cycle while `o_ready`=1.
- Control unit contract:
  - DECODE samples `outFull`; the next cycle (OUTBOX) asserts `wO` for exactly one cycle.
  - Between those cycles only reads can occur, so `outFull` can only fall. A legal CPU therefore never sets `ovf`.
  - `ovf`=1 indicates a protocol violation and is a verification check point.

## Structure
- Shared package (`hrm_pkg`): `DATA_W` default. The outbox depth constant is shared with the inbox block, which is the mirror of this block.
- One natural sub-module: `fifo_mem`, a DEPTH×DATA_W array with synchronous write and asynchronous read port. It is reused by the inbox.
- Pointer, counter and flag logic live in `outbox_fifo` itself.

## Test plan
- Reset then idle:
  - `count`=0, `o_valid`=0, `outFull`=0, `ovf`=0.
  - 20 cycles of `o_ready`=1 change nothing.
- Fill and drain (DEPTH=16, `o_ready`=0):
  - Write 0x01..0x10 → `outFull`=1 after the 16th write, `count`=16.
  - Then hold `o_ready`=1 → outputs 0x01..0x10 in order, one per cycle.
  - `o_valid` falls after the 16th read.
- Overflow: at full, pulse `wO` with `din`=0xAA → `count` stays 16, `ovf`=1, 0xAA never appears at `o_data`. Then `clr` → `ovf`=0, `count`=0.
- Concurrent read and write at `count`=5 (head 0x30): `wO`+`o_ready` with `din`=0x99 → `count` stays 5, next head is 0x31, and 0x99 emerges fifth.
- Pointer wrap:
  - Stream 40 words (0x00..0x27) with `o_ready` toggling 1-of-2 cycles.
  - Output sequence is identical to input.
  - `count` never exceeds 16, `ovf` stays 0.
- Flush mid-operation: with `count`=7, assert `clr` in the same cycle as `wO` and `o_ready` → next cycle `count`=0, `o_valid`=0. A subsequent write of 0x42 is the first word out.
